// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control word layout, instruction field
// positions and the IF/ID hazard FSM state encoding.
package pipeline_pkg;

  localparam int CTRL_W     = 22;

  // Control word field positions
  localparam int SRC_OP_HI  = 17;
  localparam int SRC_OP_LO  = 15;
  localparam int ALU_OP_HI  = 14;
  localparam int ALU_OP_LO  = 11;
  localparam int LOAD_BIT   = 10;
  localparam int RF_EN_BIT  = 9;
  localparam int BRANCH_BIT = 8;

  // Instruction register-field positions
  localparam int RS_HI      = 25;
  localparam int RS_LO      = 21;
  localparam int RT_HI      = 20;
  localparam int RT_LO      = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ifid_state_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: flags when the instruction in ID/EX is a load
// writing a non-zero register that the IF/ID instruction reads as rs or rt.
// rt is always compared, even for formats that do not read it, so the
// detector errs on the side of stalling.
module hazard_unit (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic       load,
  input  logic       rf_en,
  output logic       hazard
);

  assign hazard = load && rf_en && (rd != 5'd0) && ((rd == rs) || (rd == rt));

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with load-use stall and taken-branch flush.
// A load-use hazard freezes PC and IF/ID and forwards a zero control word
// (bubble) to ID/EX in the same cycle; a taken branch loads NOP_INSTR into
// IF/ID and zeroes the control word, and takes priority over a stall.
module ifid_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic [CTRL_W-1:0] cu_control_signals,
  input  logic [CTRL_W-1:0] idex_control_signals,
  input  logic [4:0]        idex_rd,
  input  logic              branch_taken,
  output logic [31:0]       instr_out,
  output logic [31:0]       pc_out,
  output logic [CTRL_W-1:0] control_signals_out,
  output logic              pc_le,
  output logic              ifid_le,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        hazard;
  ifid_state_t state;

  // Only the load and write-enable bits of the ID/EX control word matter here
  logic unused_idex_bits;
  assign unused_idex_bits = ^{idex_control_signals[CTRL_W-1:LOAD_BIT+1],
                              idex_control_signals[RF_EN_BIT-1:0]};

  hazard_unit u_hazard (
    .rs     (instr_out[RS_HI:RS_LO]),
    .rt     (instr_out[RT_HI:RT_LO]),
    .rd     (idex_rd),
    .load   (idex_control_signals[LOAD_BIT]),
    .rf_en  (idex_control_signals[RF_EN_BIT]),
    .hazard (hazard)
  );

  // Branch squash overrides the stall; a bubble is issued only without a branch
  assign stall               = hazard && !branch_taken;
  assign pc_le               = !stall;
  assign ifid_le             = !stall;
  assign control_signals_out = (stall || branch_taken) ? '0 : cu_control_signals;

  // IF/ID register: NOP on flush, hold on stall, otherwise capture fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_out <= NOP_INSTR;
      pc_out    <= 32'd0;
    end else if (branch_taken) begin
      instr_out <= NOP_INSTR;
      pc_out    <= pc_in;
    end else if (ifid_le) begin
      instr_out <= instr_in;
      pc_out    <= pc_in;
    end
  end

  // Saturating count of injected bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Tracks whether the previous cycle was a normal, stalled or flushed slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN, ST_STALL, ST_FLUSH: begin
          if (branch_taken)  state <= ST_FLUSH;
          else if (stall)    state <= ST_STALL;
          else               state <= ST_RUN;
        end
        default:             state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_stage.sv
// Scoreboard bench for ifid_stage (CNT_W = 4, NOP_INSTR = 0).
module tb_ifid_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [21:0] LD  = 22'h000600;   // load + rf_enable

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in, pc_in;
  logic [21:0] cu_control_signals, idex_control_signals;
  logic [4:0]  idex_rd;
  logic        branch_taken;
  logic [31:0] instr_out, pc_out;
  logic [21:0] control_signals_out;
  logic        pc_le, ifid_le, stall;
  logic [3:0]  stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  cnt;
  } exp_t;
  exp_t q[$];

  // Reference model of the IF/ID state
  logic [31:0] m_instr, m_pc;
  logic [3:0]  m_cnt;

  ifid_stage #(.NOP_INSTR(NOP), .CNT_W(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_in             (instr_in),
    .pc_in                (pc_in),
    .cu_control_signals   (cu_control_signals),
    .idex_control_signals (idex_control_signals),
    .idex_rd              (idex_rd),
    .branch_taken         (branch_taken),
    .instr_out            (instr_out),
    .pc_out               (pc_out),
    .control_signals_out  (control_signals_out),
    .pc_le                (pc_le),
    .ifid_le              (ifid_le),
    .stall                (stall),
    .stall_count          (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check same-cycle outputs, push expected register
  // state, then pop and compare after the edge.
  task automatic cycle(input logic [31:0] ii, input logic [31:0] pi, input logic [21:0] cu,
                       input logic [21:0] idc, input logic [4:0] rd, input logic br);
    logic [4:0] rs, rt;
    logic       haz, e_stall;
    exp_t       e, got;
    instr_in = ii; pc_in = pi; cu_control_signals = cu;
    idex_control_signals = idc; idex_rd = rd; branch_taken = br;
    #1;
    rs  = m_instr[25:21];
    rt  = m_instr[20:16];
    haz = idc[10] && idc[9] && (rd != 5'd0) && ((rd == rs) || (rd == rt));
    e_stall = haz && !br;
    check("stall", 32'(stall), 32'(e_stall));
    check("ctrl",  32'(control_signals_out), (e_stall || br) ? 32'd0 : 32'(cu));
    check("pc_le", 32'(pc_le), 32'(!e_stall));
    check("ifid_le", 32'(ifid_le), 32'(!e_stall));
    if (br) begin
      m_instr = NOP; m_pc = pi;
    end else if (!e_stall) begin
      m_instr = ii;  m_pc = pi;
    end
    if (e_stall && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    e.instr = m_instr; e.pc = m_pc; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk); #1;
    got = q.pop_front();
    check("instr_out",   instr_out, got.instr);
    check("pc_out",      pc_out, got.pc);
    check("stall_count", 32'(stall_count), 32'(got.cnt));
  endtask

  initial begin
    reset = 1'b1;
    instr_in = '0; pc_in = '0; cu_control_signals = '0;
    idex_control_signals = '0; idex_rd = '0; branch_taken = 1'b0;
    m_instr = NOP; m_pc = '0; m_cnt = '0;
    #2;
    check("rst_instr", instr_out, NOP);
    check("rst_pc",    pc_out, 32'd0);
    check("rst_cnt",   32'(stall_count), 32'd0);
    check("rst_pc_le", 32'(pc_le), 32'd1);
    check("rst_ifid_le", 32'(ifid_le), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    #10 reset = 1'b0;                         // released at t=12
    @(posedge clk); #1;

    // Normal flow
    cycle(32'h8C22_0004, 32'h100, 22'h12345, 22'h0, 5'd0, 1'b0);
    cycle(32'h0043_1820, 32'h104, 22'h2ABCD, 22'h0, 5'd0, 1'b0);
    // Load-use on rs (=2): one bubble, IF/ID held
    cycle(32'h0085_1020, 32'h108, 22'h11111, LD, 5'd2, 1'b0);
    check("state_stall", 32'(dut.state), 32'(ST_STALL));
    cycle(32'h0085_1020, 32'h108, 22'h11111, 22'h0, 5'd0, 1'b0);
    check("state_run", 32'(dut.state), 32'(ST_RUN));
    // Load-use on rt (=5)
    cycle(32'h0085_1020, 32'h10C, 22'h22222, LD, 5'd5, 1'b0);
    cycle(32'h0085_1020, 32'h10C, 22'h22222, 22'h0, 5'd0, 1'b0);
    // No stall: rd = 0, rf_enable = 0, load = 0
    cycle(32'h0085_1020, 32'h110, 22'h33333, LD, 5'd0, 1'b0);
    cycle(32'h0085_1020, 32'h110, 22'h33333, 22'h000400, 5'd4, 1'b0);
    cycle(32'h0085_1020, 32'h110, 22'h33333, 22'h000200, 5'd4, 1'b0);
    // Branch together with hazard: branch wins
    cycle(32'h0085_1020, 32'h200, 22'h3FFFF, LD, 5'd4, 1'b0 | 1'b1);
    check("state_flush", 32'(dut.state), 32'(ST_FLUSH));
    cycle(32'h0085_1020, 32'h204, 22'h00F00, 22'h0, 5'd0, 1'b0);
    // Saturation: 16 consecutive hazard cycles
    for (int i = 0; i < 16; i++)
      cycle(32'h0000_0000, 32'h300, 22'h0AAAA, LD, 5'd4, 1'b0);
    check("sat", 32'(stall_count), 32'd15);

    // Asynchronous reset while stalled
    idex_control_signals = LD; idex_rd = 5'd4; branch_taken = 1'b0;
    #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    m_instr = NOP; m_pc = '0; m_cnt = '0;
    check("arst_instr", instr_out, NOP);
    check("arst_pc",    pc_out, 32'd0);
    check("arst_cnt",   32'(stall_count), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_pc_le", 32'(pc_le), 32'd1);
    check("arst_state", 32'(dut.state), 32'(ST_RUN));
    @(negedge clk);
    reset = 1'b0;
    idex_control_signals = '0; idex_rd = '0;
    @(posedge clk); #1;
    check("post_rst_state", 32'(dut.state), 32'(ST_RUN));
    cycle(32'h8C22_0004, 32'h400, 22'h15555, 22'h0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
